// File: rtl/mem_bus_master_pkg.sv
// Shared CPU bus definitions: FSM encoding, transaction owner and lane constants.
// Imported by the memory bus master and by any block that decodes its state.
package mem_bus_master_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    function automatic logic [31:0] word_addr(input logic [29:0] wa);
        return {wa, 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_master.sv
// Avalon-MM master arbitrating fetch/data requests into single word transfers.
// Latency 2 + waitrequest cycles to ack; bus outputs held stable under waitrequest.
module mem_bus_master
    import mem_bus_master_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_byteenable,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,

    output logic        addr_err,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    logic [1:0]  state_q,      state_d;
    owner_e      owner_q,      owner_d;
    logic        we_q,         we_d;
    logic [31:0] address_q,    address_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] writedata_q,  writedata_d;
    logic        read_q,       read_d;
    logic        write_q,      write_d;
    logic        if_ack_q,     if_ack_d;
    logic        dm_ack_q,     dm_ack_d;
    logic        addr_err_q,   addr_err_d;
    logic [31:0] if_rdata_q,   if_rdata_d;
    logic [31:0] dm_rdata_q,   dm_rdata_d;

    // Sub-word offset of a data access is resolved by the byte-lane stage.
    logic unused_dm_offset;
    assign unused_dm_offset = ^dm_addr[1:0];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        address_d    = address_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        read_d       = read_q;
        write_d      = write_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        addr_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Data wins: it belongs to the older instruction in the pipe.
                if (dm_req) begin
                    owner_d = OWN_DATA;
                    we_d    = dm_we;
                    if (dm_we && (dm_byteenable == 4'b0000)) begin
                        state_d  = ST_RESP;
                        dm_ack_d = 1'b1;
                    end else begin
                        state_d      = ST_BUS;
                        address_d    = word_addr(dm_addr[31:2]);
                        byteenable_d = dm_byteenable;
                        writedata_d  = dm_wdata;
                        read_d       = ~dm_we;
                        write_d      = dm_we;
                    end
                end else if (if_req) begin
                    owner_d = OWN_FETCH;
                    we_d    = 1'b0;
                    if (if_addr[1:0] != 2'b00) begin
                        state_d    = ST_RESP;
                        if_ack_d   = 1'b1;
                        addr_err_d = 1'b1;
                    end else begin
                        // Fetches carry no write payload; drive zeros rather than stale data.
                        state_d      = ST_BUS;
                        address_d    = word_addr(if_addr[31:2]);
                        byteenable_d = BE_WORD;
                        writedata_d  = 32'h0;
                        read_d       = 1'b1;
                    end
                end
            end

            ST_BUS: begin
                if (!waitrequest) begin
                    state_d = ST_RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (owner_q == OWN_FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = readdata;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = readdata;
                        end
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            we_q         <= 1'b0;
            address_q    <= 32'h0;
            byteenable_q <= 4'h0;
            writedata_q  <= 32'h0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            addr_err_q   <= 1'b0;
            if_rdata_q   <= 32'h0;
            dm_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            addr_err_q   <= addr_err_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign address    = address_q;
    assign byteenable = byteenable_q;
    assign writedata  = writedata_q;
    assign read       = read_q;
    assign write      = write_q;
    assign if_ack     = if_ack_q;
    assign dm_ack     = dm_ack_q;
    assign addr_err   = addr_err_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;

endmodule
